// File: rtl/regfile_sb.sv
// Decode-stage register file: multi-port combinational reads, write-through
// bypass, and a per-register busy scoreboard for load-use stalls.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREAD*ADDR_W-1:0] rd_addr,
  output logic [NREAD*DATA_W-1:0] rd_data,
  output logic [NREAD-1:0]        rd_busy,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    res_en,
  input  logic [ADDR_W-1:0]       res_addr,
  output logic [2**ADDR_W-1:0]    busy_vec
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  // Writeback clears before issue sets, so a same-cycle
  // reservation of the written register leaves it busy.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_en) begin
      regs_d[wr_addr] = wr_data;
      busy_d[wr_addr] = 1'b0;
    end
    if (res_en) begin
      busy_d[res_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      regs_d[0] = '0;
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              zero;
    logic              hit;

    assign a    = rd_addr[g*ADDR_W +: ADDR_W];
    assign zero = (ZERO_REG != 0) && (a == '0);
    assign hit  = (BYPASS != 0) && wr_en
                  && (wr_addr == a) && !zero;

    assign rd_data[g*DATA_W +: DATA_W] =
      zero ? '0 : (hit ? wr_data : regs_q[a]);
    assign rd_busy[g] = busy_q[a] & ~hit & ~zero;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed table, hand sequences,
// and a randomized run against a reference model.
module tb_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_busy_a, rd_busy_b;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        res_en;
  logic [4:0]  res_addr;
  logic [31:0] bv_a, bv_b;

  logic        c_rst_n;
  logic [11:0] c_rd_addr;
  logic [47:0] c_rd_data;
  logic [2:0]  c_rd_busy;
  logic        c_wr_en;
  logic [3:0]  c_wr_addr;
  logic [15:0] c_wr_data;
  logic        c_res_en;
  logic [3:0]  c_res_addr;
  logic [15:0] c_busy_vec;

  int total = 0;
  int bad   = 0;

  regfile_sb u_a (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_busy(rd_busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data),
    .res_en(res_en), .res_addr(res_addr),
    .busy_vec(bv_a)
  );

  regfile_sb #(.BYPASS(0)) u_b (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data),
    .res_en(res_en), .res_addr(res_addr),
    .busy_vec(bv_b)
  );

  regfile_sb #(
    .DATA_W(16), .ADDR_W(4), .NREAD(3)
  ) u_c (
    .clk(clk), .rst_n(c_rst_n),
    .rd_addr(c_rd_addr), .rd_data(c_rd_data),
    .rd_busy(c_rd_busy),
    .wr_en(c_wr_en), .wr_addr(c_wr_addr),
    .wr_data(c_wr_data),
    .res_en(c_res_en), .res_addr(c_res_addr),
    .busy_vec(c_busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        res;
    logic [4:0]  ra;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en  = 1'b0;
    res_en = 1'b0;
  endtask

  logic [15:0] m_regs [16];
  logic [15:0] m_busy;

  initial begin
    rst_n = 1'b0; rd_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    res_en = 1'b0; res_addr = '0;
    c_rst_n = 1'b0; c_rd_addr = '0;
    c_wr_en = 1'b0; c_wr_addr = '0;
    c_wr_data = '0; c_res_en = 1'b0;
    c_res_addr = '0;

    tbl[0]  = '{1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0,
                5'd5, 5'd5, 32'h12345678,
                32'h12345678, 2'b00};
    tbl[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                5'd5, 5'd5, 32'h12345678,
                32'h12345678, 2'b00};
    tbl[2]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0,
                5'd0, 5'd5, 32'h0,
                32'h12345678, 2'b00};
    tbl[3]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                5'd0, 5'd0, 32'h0, 32'h0, 2'b00};
    tbl[4]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9,
                5'd9, 5'd5, 32'h0,
                32'h12345678, 2'b00};
    tbl[5]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                5'd9, 5'd9, 32'h0, 32'h0, 2'b11};
    tbl[6]  = '{1'b1, 5'd9, 32'h55, 1'b0, 5'd0,
                5'd9, 5'd5, 32'h55,
                32'h12345678, 2'b00};
    tbl[7]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                5'd9, 5'd9, 32'h55, 32'h55, 2'b00};
    tbl[8]  = '{1'b1, 5'd9, 32'h66, 1'b1, 5'd9,
                5'd9, 5'd0, 32'h66, 32'h0, 2'b00};
    tbl[9]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                5'd9, 5'd9, 32'h66, 32'h66, 2'b11};
    tbl[10] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0,
                5'd0, 5'd9, 32'h0, 32'h66, 2'b10};
    tbl[11] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                5'd0, 5'd9, 32'h0, 32'h66, 2'b10};

    // Reset while a write to r3 is held
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd3;
    wr_data = 32'hDEAD;
    tick();
    tick();
    rst_n = 1'b1;
    idle();
    rd_addr = {5'd3, 5'd3};
    #1;
    chk("rst_rd_a", rd_data_a, 64'h0);
    chk("rst_rd_b", rd_data_b, 64'h0);
    chk("rst_busy", {rd_busy_a, rd_busy_b}, 64'h0);
    chk("rst_bv_a", bv_a, 64'h0);
    chk("rst_bv_b", bv_b, 64'h0);
    tick();

    for (int i = 0; i < 12; i++) begin
      wr_en    = tbl[i].wr;
      wr_addr  = tbl[i].wa;
      wr_data  = tbl[i].wd;
      res_en   = tbl[i].res;
      res_addr = tbl[i].ra;
      rd_addr  = {tbl[i].a1, tbl[i].a0};
      #1;
      chk($sformatf("tbl%0d_d0", i),
          rd_data_a[31:0], tbl[i].e0);
      chk($sformatf("tbl%0d_d1", i),
          rd_data_a[63:32], tbl[i].e1);
      chk($sformatf("tbl%0d_bz", i),
          rd_busy_a, tbl[i].eb);
      tick();
    end
    idle();
    #1;
    chk("bv0_zero", bv_a[0], 1'b0);
    chk("bv9_busy", bv_a[9], 1'b1);

    // Bypass versus no bypass on r7
    wr_en = 1'b1; wr_addr = 5'd7;
    wr_data = 32'hA5A5A5A5;
    rd_addr = {5'd9, 5'd7};
    #1;
    chk("byp_on", rd_data_a[31:0], 32'hA5A5A5A5);
    chk("byp_off", rd_data_b[31:0], 32'h0);
    tick();
    idle();
    #1;
    chk("byp_off_nx", rd_data_b[31:0], 32'hA5A5A5A5);

    // Reserve r10, write it back four cycles later
    res_en = 1'b1; res_addr = 5'd10;
    rd_addr = {5'd10, 5'd10};
    #1;
    chk("res_c0", rd_busy_a, 2'b00);
    tick();
    idle();
    for (int c = 1; c < 4; c++) begin
      #1;
      chk($sformatf("res_c%0d", c), rd_busy_a, 2'b11);
      tick();
    end
    wr_en = 1'b1; wr_addr = 5'd10;
    wr_data = 32'h55;
    rd_addr = {5'd9, 5'd10};
    #1;
    chk("wb_c4_bz_a", rd_busy_a[0], 1'b0);
    chk("wb_c4_d_a", rd_data_a[31:0], 32'h55);
    chk("wb_c4_bz_b", rd_busy_b[0], 1'b1);
    chk("wb_c4_bv", bv_a[10], 1'b1);
    tick();
    idle();
    #1;
    chk("wb_c5_bv_a", bv_a[10], 1'b0);
    chk("wb_c5_bv_b", bv_b[10], 1'b0);
    chk("wb_c5_d_b", rd_data_b[31:0], 32'h55);
    tick();

    // Reset mid-operation with r4 busy and holding data
    wr_en = 1'b1; wr_addr = 5'd4;
    wr_data = 32'h77;
    res_en = 1'b1; res_addr = 5'd4;
    tick();
    idle();
    rd_addr = {5'd0, 5'd4};
    #1;
    chk("r4_busy", bv_a[4], 1'b1);
    chk("r4_data", rd_data_a[31:0], 32'h77);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("mid_rst_bv_a", bv_a, 32'h0);
    chk("mid_rst_bv_b", bv_b, 32'h0);
    chk("mid_rst_r4", rd_data_a[31:0], 32'h0);
    tick();

    // Randomized run on the 3-port, 16-bit instance
    c_rst_n = 1'b0;
    tick();
    for (int r = 0; r < 16; r++) m_regs[r] = '0;
    m_busy = '0;
    for (int n = 0; n < 10000; n++) begin
      c_rst_n    = ($urandom_range(0, 199) != 0);
      c_wr_en    = 1'($urandom_range(0, 1));
      c_wr_addr  = 4'($urandom_range(0, 15));
      c_wr_data  = 16'($urandom);
      c_res_en   = 1'($urandom_range(0, 1));
      c_res_addr = 4'($urandom_range(0, 15));
      c_rd_addr  = 12'($urandom);
      for (int p = 0; p < 3; p++) begin
        if ($urandom_range(0, 3) == 0)
          c_rd_addr[p*4 +: 4] = c_wr_addr;
      end
      #1;
      for (int p = 0; p < 3; p++) begin
        int          a;
        logic [15:0] ed;
        logic        eb;
        a = int'(c_rd_addr[p*4 +: 4]);
        if (a == 0) begin
          ed = '0; eb = 1'b0;
        end else if (c_wr_en && int'(c_wr_addr) == a) begin
          ed = c_wr_data; eb = 1'b0;
        end else begin
          ed = m_regs[a]; eb = m_busy[a];
        end
        chk($sformatf("rnd%0d_d%0d", n, p),
            c_rd_data[p*16 +: 16], ed);
        chk($sformatf("rnd%0d_b%0d", n, p),
            c_rd_busy[p], eb);
      end
      chk($sformatf("rnd%0d_bv", n), c_busy_vec, m_busy);
      @(posedge clk);
      if (!c_rst_n) begin
        for (int r = 0; r < 16; r++) m_regs[r] = '0;
        m_busy = '0;
      end else begin
        if (c_wr_en && c_wr_addr != 4'd0) begin
          m_regs[c_wr_addr] = c_wr_data;
          m_busy[c_wr_addr] = 1'b0;
        end
        if (c_res_en && c_res_addr != 4'd0)
          m_busy[c_res_addr] = 1'b1;
      end
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
